// File: rtl/pong_pkg.sv
// Shared types and glyph geometry for the pong display overlays.
// seg7 returns segments packed as {g, f, e, d, c, b, a}.
package pong_pkg;

    typedef enum logic [1:0] {
        ST_SET,
        ST_RUN,
        ST_PAUSE,
        ST_DONE
    } timer_state_t;

    localparam int DIGIT_W = 25;
    localparam int DIGIT_H = 45;
    localparam int SEG_T   = 5;

    function automatic logic [6:0] seg7(input logic [3:0] digit);
        logic [6:0] segs;
        case (digit)
            4'd0:    segs = 7'h3F;
            4'd1:    segs = 7'h06;
            4'd2:    segs = 7'h5B;
            4'd3:    segs = 7'h4F;
            4'd4:    segs = 7'h66;
            4'd5:    segs = 7'h6D;
            4'd6:    segs = 7'h7D;
            4'd7:    segs = 7'h07;
            4'd8:    segs = 7'h7F;
            4'd9:    segs = 7'h6F;
            default: segs = 7'h00;
        endcase
        return segs;
    endfunction

endpackage

// File: rtl/seg_glyph.sv
// One seven-segment digit glyph; pixel is high when (x, y) falls on a lit segment.
module seg_glyph
    import pong_pkg::*;
(
    input  logic [3:0] digit,
    input  logic [9:0] origin_x,
    input  logic [9:0] origin_y,
    input  logic [9:0] x,
    input  logic [9:0] y,
    output logic       pixel
);

    localparam logic [10:0] GW    = 11'(DIGIT_W);
    localparam logic [10:0] GH    = 11'(DIGIT_H);
    localparam logic [10:0] GT    = 11'(SEG_T);
    localparam logic [10:0] MID0  = 11'((DIGIT_H - SEG_T) / 2);
    localparam logic [10:0] MID1  = MID0 + GT;
    localparam logic [10:0] RIGHT = GW - GT;
    localparam logic [10:0] BOT   = GH - GT;

    logic [10:0] dx, dy;
    logic [6:0]  segs;
    logic        in_box, col_l, col_r, mid_cols;
    logic        row_top, row_mid, row_bot, upper, lower;

    // Pixels left of / above the origin wrap to large values and fall outside the box.
    assign dx = {1'b0, x} - {1'b0, origin_x};
    assign dy = {1'b0, y} - {1'b0, origin_y};

    assign segs     = seg7(digit);
    assign in_box   = (dx < GW) && (dy < GH);
    assign col_l    = dx < GT;
    assign col_r    = dx >= RIGHT;
    assign mid_cols = !col_l && !col_r;
    assign row_top  = dy < GT;
    assign row_mid  = (dy >= MID0) && (dy < MID1);
    assign row_bot  = dy >= BOT;
    assign upper    = dy < MID1;
    assign lower    = dy >= MID0;

    // The middle bar stops at the vertical columns, which own the corners on that row.
    assign pixel = in_box && (
                       (segs[0] && row_top)
                    || (segs[3] && row_bot)
                    || (segs[6] && row_mid && mid_cols)
                    || (segs[5] && col_l && upper)
                    || (segs[1] && col_r && upper)
                    || (segs[4] && col_l && lower)
                    || (segs[2] && col_r && lower));

endmodule

// File: rtl/match_timer_display.sv
// Match clock: settable m:ss countdown at 1 Hz with pause/restart, timeout pulse
// and a seven-segment pixel overlay with blinking colon.
//   state | meaning
//   SET   | adjusting set_value, field shows set_value, colon steady
//   RUN   | counting down, colon blinks with the prescaler
//   PAUSE | countdown frozen, prescaler held, colon steady
//   DONE  | reached 0, whole field blinks on the half-second toggle
module match_timer_display
    import pong_pkg::*;
#(
    parameter int MAX_SECONDS     = 599,
    parameter int DEFAULT_SECONDS = 180,
    parameter int STEP_SECONDS    = 15,
    parameter int TICK_DIV        = 25_000_000,
    parameter int ORIGIN_X        = 266,
    parameter int ORIGIN_Y        = 240,
    parameter int DIGIT_PITCH     = 31
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 mode_set,
    input  logic                                 inc,
    input  logic                                 dec,
    input  logic                                 start,
    input  logic                                 pause_toggle,
    input  logic [9:0]                           x,
    input  logic [9:0]                           y,
    output logic [$clog2(MAX_SECONDS+1)-1:0]     seconds_left,
    output logic [3:0]                           min_digit,
    output logic [3:0]                           sec_tens,
    output logic [3:0]                           sec_ones,
    output logic                                 running,
    output logic                                 timeout,
    output logic                                 display
);

    localparam int W  = $clog2(MAX_SECONDS + 1);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [W-1:0]  MAX_V     = W'(MAX_SECONDS);
    localparam logic [W-1:0]  STEP_V    = W'(STEP_SECONDS);
    localparam logic [W-1:0]  DEF_V     = W'(DEFAULT_SECONDS);
    localparam logic [W-1:0]  DEC_FLOOR = W'(2 * STEP_SECONDS);
    localparam logic [W-1:0]  ONE_V     = W'(1);
    localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PRE_HALF  = PW'(TICK_DIV / 2);
    localparam logic [PW-1:0] PRE_MID   = PW'(TICK_DIV / 2 - 1);

    localparam logic [9:0] D0_X  = 10'(ORIGIN_X);
    localparam logic [9:0] D1_X  = 10'(ORIGIN_X + DIGIT_PITCH + 10);
    localparam logic [9:0] D2_X  = 10'(ORIGIN_X + 2 * DIGIT_PITCH + 10);
    localparam logic [9:0] D_Y   = 10'(ORIGIN_Y);
    localparam logic [9:0] C_X0  = 10'(ORIGIN_X + 28);
    localparam logic [9:0] C_X1  = 10'(ORIGIN_X + 32);
    localparam logic [9:0] C_YA0 = 10'(ORIGIN_Y + 10);
    localparam logic [9:0] C_YA1 = 10'(ORIGIN_Y + 14);
    localparam logic [9:0] C_YB0 = 10'(ORIGIN_Y + 30);
    localparam logic [9:0] C_YB1 = 10'(ORIGIN_Y + 34);

    timer_state_t  state_q, state_d;
    logic [W-1:0]  set_q, set_d, rem_q, rem_d, adj_set, sec_mod;
    logic [PW-1:0] pre_q, pre_d, pre_next;
    logic          blink_q, blink_d, timeout_d;
    logic          pre_wrap, pre_mid;

    assign pre_wrap = pre_q == PRE_LAST;
    assign pre_mid  = pre_q == PRE_MID;
    assign pre_next = pre_wrap ? '0 : pre_q + 1'b1;

    always_comb begin
        adj_set = set_q;
        if (inc && !dec)
            adj_set = (set_q >= MAX_V - STEP_V) ? MAX_V : set_q + STEP_V;
        else if (dec && !inc)
            adj_set = (set_q < DEC_FLOOR) ? STEP_V : set_q - STEP_V;
    end

    always_comb begin
        state_d   = state_q;
        set_d     = set_q;
        rem_d     = rem_q;
        pre_d     = pre_q;
        blink_d   = blink_q;
        timeout_d = 1'b0;
        if (mode_set) begin
            state_d = ST_SET;
            set_d   = (state_q == ST_SET) ? adj_set : set_q;
            rem_d   = (state_q == ST_SET) ? adj_set : set_q;
        end else begin
            case (state_q)
                ST_SET: begin
                    set_d = adj_set;
                    rem_d = adj_set;
                    if (start) begin
                        state_d = ST_RUN;
                        pre_d   = '0;
                    end
                end
                ST_RUN: begin
                    if (start) begin
                        rem_d = set_q;
                        pre_d = '0;
                    end else if (pause_toggle) begin
                        state_d = ST_PAUSE;
                    end else begin
                        pre_d = pre_next;
                        if (pre_wrap || pre_mid)
                            blink_d = !blink_q;
                        if (pre_wrap) begin
                            if (rem_q <= ONE_V) begin
                                rem_d     = '0;
                                timeout_d = (rem_q == ONE_V);
                                state_d   = ST_DONE;
                            end else begin
                                rem_d = rem_q - 1'b1;
                            end
                        end
                    end
                end
                ST_PAUSE: begin
                    if (pause_toggle)
                        state_d = ST_RUN;
                end
                ST_DONE: begin
                    rem_d = '0;
                    if (start) begin
                        state_d = ST_RUN;
                        rem_d   = set_q;
                        pre_d   = '0;
                    end else begin
                        pre_d = pre_next;
                        if (pre_wrap || pre_mid)
                            blink_d = !blink_q;
                    end
                end
                default: state_d = ST_SET;
            endcase
        end
    end

    assign seconds_left = (state_q == ST_SET) ? set_q : rem_q;
    assign sec_mod      = W'(seconds_left % 60);
    assign running      = state_q == ST_RUN;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_SET;
            set_q     <= DEF_V;
            rem_q     <= DEF_V;
            pre_q     <= '0;
            blink_q   <= 1'b0;
            timeout   <= 1'b0;
            min_digit <= 4'(DEFAULT_SECONDS / 60);
            sec_tens  <= 4'((DEFAULT_SECONDS % 60) / 10);
            sec_ones  <= 4'(DEFAULT_SECONDS % 10);
        end else begin
            state_q   <= state_d;
            set_q     <= set_d;
            rem_q     <= rem_d;
            pre_q     <= pre_d;
            blink_q   <= blink_d;
            timeout   <= timeout_d;
            min_digit <= 4'(seconds_left / 60);
            sec_tens  <= 4'(sec_mod / 10);
            sec_ones  <= 4'(sec_mod % 10);
        end
    end

    logic px0, px1, px2, colon_px, colon_en, field_en;

    seg_glyph u_min  (.digit(min_digit), .origin_x(D0_X), .origin_y(D_Y), .x(x), .y(y), .pixel(px0));
    seg_glyph u_tens (.digit(sec_tens),  .origin_x(D1_X), .origin_y(D_Y), .x(x), .y(y), .pixel(px1));
    seg_glyph u_ones (.digit(sec_ones),  .origin_x(D2_X), .origin_y(D_Y), .x(x), .y(y), .pixel(px2));

    assign colon_px = (x >= C_X0) && (x <= C_X1)
                   && (((y >= C_YA0) && (y <= C_YA1)) || ((y >= C_YB0) && (y <= C_YB1)));

    always_comb begin
        colon_en = 1'b1;
        if (state_q == ST_RUN)
            colon_en = pre_q < PRE_HALF;
    end

    assign field_en = (state_q != ST_DONE) || blink_q;
    assign display  = field_en && (px0 || px1 || px2 || (colon_en && colon_px));

endmodule
